// File: rtl/zm_to_u2.sv
// Bit-serial sign-magnitude to two's-complement converter, LSB first, with a
// start/done/ack handshake that holds the result until the consumer takes it.
module zm_to_u2 #(
   parameter int M = 8,
   parameter int K = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [M-1:0] i_arg_A,
   input  logic         i_ack,
   output logic         o_busy,
   output logic         o_done,
   output logic [K-1:0] o_result,
   output logic [3:0]   o_status
);

   localparam int CW = (M > 2) ? $clog2(M - 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          sign_q, sign_d;
   logic [M-2:0]  mag_q, mag_d;
   logic [K-1:0]  result_q, result_d;
   logic [3:0]    status_q, status_d;
   logic          bitX;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         result_q <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         result_q <= result_d;
         status_q <= status_d;
      end
   end

   // Negation is invert-and-add-one done serially: the carry starts at the
   // sign, so positive operands pass through unchanged.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      result_d = result_q;
      status_d = status_q;
      bitX     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               sign_d   = i_arg_A[M-1];
               mag_d    = i_arg_A[M-2:0];
               result_d = '0;
               status_d = '0;
               cnt_d    = '0;
               carry_d  = i_arg_A[M-1];
               state_d  = BUSY;
            end
         end
         BUSY: begin
            bitX             = mag_q[cnt_q] ^ sign_q;
            result_d[cnt_q]  = bitX ^ carry_q;
            carry_d          = bitX & carry_q;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Sign extension; negative zero collapses to plain zero.
               for (int i = M - 1; i < K; i++) begin
                  result_d[i] = sign_q & (|mag_q);
               end
               status_d = (sign_q && (mag_q == '0)) ? 4'b1001 : 4'b0000;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (i_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_busy   = (state_q == BUSY);
   assign o_done   = (state_q == DONE);
   assign o_result = result_q;
   assign o_status = status_q;

endmodule
